// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serialises instruction fetches and load/store
// requests onto the 8-bit RAM/IO port and reassembles read data little-endian.
module mem_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              clr_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              if_to_mc_ready,
    input  logic [ADDR_W-1:0] if_to_mc_PC,
    output logic              mc_to_if_ready,
    output logic [31:0]       mc_to_if_inst,
    input  logic              lsb_to_mc_ready,
    input  logic              lsb_to_mc_wr,
    input  logic [1:0]        lsb_to_mc_width,
    input  logic [ADDR_W-1:0] lsb_to_mc_addr,
    input  logic [31:0]       lsb_to_mc_data,
    output logic              mc_to_lsb_ready,
    output logic [31:0]       mc_to_lsb_data
);

    typedef enum logic [2:0] {
        IDLE,
        IF_READ,
        LS_READ,
        LS_WRITE,
        DONE
    } state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [2:0]        r_len;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;
    logic [ADDR_W-1:0] r_memA;
    logic              r_memWr;
    logic [7:0]        r_memDout;
    logic              r_ifReady;
    logic [31:0]       r_ifInst;
    logic              r_lsbReady;
    logic [31:0]       r_lsbData;

    state_t            w_stateNext;
    logic [2:0]        w_cntNext;
    logic [2:0]        w_lenNext;
    logic [ADDR_W-1:0] w_addrNext;
    logic [31:0]       w_wdataNext;
    logic [31:0]       w_bufNext;
    logic [ADDR_W-1:0] w_memANext;
    logic              w_memWrNext;
    logic [7:0]        w_memDoutNext;
    logic              w_ifReadyNext;
    logic [31:0]       w_ifInstNext;
    logic              w_lsbReadyNext;
    logic [31:0]       w_lsbDataNext;

    logic [2:0]        w_reqLen;
    logic [2:0]        w_issueIdx;
    logic [2:0]        w_capIdx;
    logic [ADDR_W-1:0] w_rdAddr;
    logic [ADDR_W-1:0] w_wrAddr;
    logic              w_wrStall;
    logic [7:0]        w_wrByte;
    logic [31:0]       w_capBuf;

    // In the read states r_cnt counts edges since accept: the edge seeing
    // count c drives address c+1 and captures byte c-1, since RAM data trails
    // its address by one full cycle. In LS_WRITE r_cnt is the byte in flight.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_lenNext      = r_len;
        w_addrNext     = r_addr;
        w_wdataNext    = r_wdata;
        w_bufNext      = r_buf;
        w_memANext     = r_memA;
        w_memWrNext    = r_memWr;
        w_memDoutNext  = r_memDout;
        w_ifReadyNext  = 1'b0;
        w_ifInstNext   = r_ifInst;
        w_lsbReadyNext = 1'b0;
        w_lsbDataNext  = r_lsbData;

        case (lsb_to_mc_width)
            2'd0:    w_reqLen = 3'd1;
            2'd1:    w_reqLen = 3'd2;
            default: w_reqLen = 3'd4;
        endcase

        w_issueIdx = r_cnt + 3'd1;
        w_capIdx   = r_cnt - 3'd1;
        w_rdAddr   = r_addr + ADDR_W'(w_issueIdx);
        w_wrAddr   = r_addr + ADDR_W'(r_cnt);
        w_wrStall  = (w_wrAddr >= IO_BASE) && io_buffer_full;
        w_wrByte   = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
        w_capBuf   = r_buf;
        w_capBuf[{w_capIdx[1:0], 3'b000} +: 8] = mem_din;

        case (r_state)
            IDLE: begin
                if (!clr_in) begin
                    if (lsb_to_mc_ready) begin
                        w_addrNext    = lsb_to_mc_addr;
                        w_lenNext     = w_reqLen;
                        w_wdataNext   = lsb_to_mc_data;
                        w_bufNext     = 32'd0;
                        w_memANext    = lsb_to_mc_addr;
                        w_memDoutNext = lsb_to_mc_data[7:0];
                        if (lsb_to_mc_wr) begin
                            w_stateNext = LS_WRITE;
                            if ((lsb_to_mc_addr >= IO_BASE) && io_buffer_full) begin
                                w_memWrNext = 1'b0;
                                w_cntNext   = 3'd0;
                            end else begin
                                w_memWrNext = 1'b1;
                                w_cntNext   = 3'd1;
                            end
                        end else begin
                            w_stateNext = LS_READ;
                            w_memWrNext = 1'b0;
                            w_cntNext   = 3'd0;
                        end
                    end else if (if_to_mc_ready) begin
                        w_stateNext   = IF_READ;
                        w_addrNext    = if_to_mc_PC;
                        w_lenNext     = 3'd4;
                        w_bufNext     = 32'd0;
                        w_memANext    = if_to_mc_PC;
                        w_memWrNext   = 1'b0;
                        w_memDoutNext = 8'd0;
                        w_cntNext     = 3'd0;
                    end
                end
            end

            IF_READ, LS_READ: begin
                if (clr_in) begin
                    w_stateNext = IDLE;
                    w_memWrNext = 1'b0;
                    w_memANext  = '0;
                    w_bufNext   = 32'd0;
                    w_cntNext   = 3'd0;
                end else begin
                    if (r_cnt != 3'd0) begin
                        w_bufNext = w_capBuf;
                    end
                    if (r_cnt == r_len) begin
                        w_stateNext = DONE;
                        w_cntNext   = 3'd0;
                        w_memANext  = '0;
                        if (r_state == IF_READ) begin
                            w_ifReadyNext = 1'b1;
                            w_ifInstNext  = w_capBuf;
                        end else begin
                            w_lsbReadyNext = 1'b1;
                            w_lsbDataNext  = w_capBuf;
                        end
                    end else begin
                        w_cntNext  = w_issueIdx;
                        w_memANext = (w_issueIdx < r_len) ? w_rdAddr : '0;
                    end
                end
            end

            // A flush never interrupts a store: it is already committed.
            LS_WRITE: begin
                if (r_cnt == r_len) begin
                    w_stateNext    = DONE;
                    w_cntNext      = 3'd0;
                    w_memWrNext    = 1'b0;
                    w_memANext     = '0;
                    w_lsbReadyNext = 1'b1;
                end else begin
                    w_memANext    = w_wrAddr;
                    w_memDoutNext = w_wrByte;
                    if (w_wrStall) begin
                        w_memWrNext = 1'b0;
                    end else begin
                        w_memWrNext = 1'b1;
                        w_cntNext   = r_cnt + 3'd1;
                    end
                end
            end

            DONE: begin
                w_stateNext = IDLE;
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= IDLE;
            r_cnt      <= 3'd0;
            r_len      <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_buf      <= 32'd0;
            r_memA     <= '0;
            r_memWr    <= 1'b0;
            r_memDout  <= 8'd0;
            r_ifReady  <= 1'b0;
            r_ifInst   <= 32'd0;
            r_lsbReady <= 1'b0;
            r_lsbData  <= 32'd0;
        end else if (rdy_in) begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_len      <= w_lenNext;
            r_addr     <= w_addrNext;
            r_wdata    <= w_wdataNext;
            r_buf      <= w_bufNext;
            r_memA     <= w_memANext;
            r_memWr    <= w_memWrNext;
            r_memDout  <= w_memDoutNext;
            r_ifReady  <= w_ifReadyNext;
            r_ifInst   <= w_ifInstNext;
            r_lsbReady <= w_lsbReadyNext;
            r_lsbData  <= w_lsbDataNext;
        end
    end

    assign mem_a           = r_memA;
    assign mem_wr          = r_memWr;
    assign mem_dout        = r_memDout;
    assign mc_to_if_ready  = r_ifReady;
    assign mc_to_if_inst   = r_ifInst;
    assign mc_to_lsb_ready = r_lsbReady;
    assign mc_to_lsb_data  = r_lsbData;

endmodule
